// File: rtl/sfu_float_lane_drain_if.sv
// Lane-vector capture and packed-word stream signals for sfu_float_lane_drain.
interface sfu_float_lane_drain_if #(
  parameter int unsigned LANES = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic                         dst_valid;
  logic [LANES-1:0][22:0]       dst_man;
  logic [LANES-1:0][7:0]        dst_exp;
  logic [LANES-1:0]             dst_sign;
  logic                         out_valid;
  logic                         out_ready;
  logic [31:0]                  out_data;
  logic                         out_last;
  logic [$clog2(DEPTH):0]       free_slots;
  logic                         ovf;
  logic [CNT_W-1:0]             drop_cnt;
  logic                         ovf_clr;

  modport master (
    output dst_valid, dst_man, dst_exp, dst_sign, out_ready, ovf_clr,
    input  out_valid, out_data, out_last, free_slots, ovf, drop_cnt
  );

  modport slave (
    input  dst_valid, dst_man, dst_exp, dst_sign, out_ready, ovf_clr,
    output out_valid, out_data, out_last, free_slots, ovf, drop_cnt
  );
endinterface

// File: rtl/sfu_float_lane_drain.sv
// Buffers SFU lane vectors in a vector FIFO and serializes them as packed IEEE-754 words.
// Optional flush-to-zero of exp==0 lanes on output: define SFU_DRAIN_FTZ_EN.
module sfu_float_lane_drain #(
  parameter int unsigned LANES = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  sfu_float_lane_drain_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(LANES);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
  localparam logic [LW-1:0] LAST_C  = LW'(LANES-1);

  logic [31:0]      mem_q [DEPTH][LANES];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d, free_q, free_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             hs, pop, push, drop;
  logic [31:0]      word;

  always_comb begin
    hs   = (count_q != '0) && bus.out_ready;
    pop  = hs && (lane_q == LAST_C);
    // A full FIFO still accepts when its head vector retires on this same edge.
    push = bus.dst_valid && ((count_q != DEPTH_C) || pop);
    drop = bus.dst_valid && !push;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lane_d   = lane_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    if (hs) lane_d = pop ? '0 : lane_q + LW'(1);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    free_d = DEPTH_C - count_d;

    // Clear is applied first so a coincident drop restarts the count at one.
    if (bus.ovf_clr) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_d != '1) drop_d = drop_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lane_q   <= '0;
      count_q  <= '0;
      free_q   <= DEPTH_C;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lane_q   <= lane_d;
      count_q  <= count_d;
      free_q   <= free_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        mem_q[wr_ptr_q][l] <= {bus.dst_sign[l], bus.dst_exp[l], bus.dst_man[l]};
      end
    end
  end

  always_comb begin
    word = mem_q[rd_ptr_q][lane_q];
`ifdef SFU_DRAIN_FTZ_EN
    if (word[30:23] == '0) word[22:0] = '0;
`endif
  end

  assign bus.out_valid  = (count_q != '0);
  assign bus.out_data   = (count_q != '0) ? word : '0;
  assign bus.out_last   = (count_q != '0) && (lane_q == LAST_C);
  assign bus.free_slots = free_q;
  assign bus.ovf        = ovf_q;
  assign bus.drop_cnt   = drop_q;
endmodule
